// File: rtl/branch_step_sequencer.sv
// rtl/branch_step_sequencer.sv - conditional-branch step sequencer (T0..T6) for the 1-bus datapath
// Drives CONin in T3 and gates the T6 PC load with the captured CON flip-flop value.
module branch_step_sequencer #(
  parameter logic [4:0] BR_OPCODE   = 5'b10010,
  parameter int         MEM_TIMEOUT = 15,
  parameter int         CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic             i_mem_ready,
  input  logic [4:0]       i_ir_opcode,
  input  logic             i_con_ff,
  output logic             o_pc_out,
  output logic             o_mar_in,
  output logic             o_inc_pc,
  output logic             o_z_in,
  output logic             o_zlow_out,
  output logic             o_pc_in,
  output logic             o_read,
  output logic             o_mdr_in,
  output logic             o_mdr_out,
  output logic             o_ir_in,
  output logic             o_gra,
  output logic             o_r_out,
  output logic             o_con_in,
  output logic             o_y_in,
  output logic             o_c_out,
  output logic             o_add,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_taken,
  output logic             o_err,
  output logic [CNT_W-1:0] o_taken_cnt,
  output logic [CNT_W-1:0] o_nottaken_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_err;
  logic                r_taken;
  logic [CNT_W-1:0]    r_taken_cnt;
  logic [CNT_W-1:0]    r_nottaken_cnt;
  logic                w_is_branch;
  logic                w_timeout;

  assign w_is_branch = (i_ir_opcode == BR_OPCODE);
  // The cycle that would be the last permitted wait gives up instead of waiting again.
  assign w_timeout   = !i_mem_ready && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next     = r_state;
    o_pc_out   = 1'b0;
    o_mar_in   = 1'b0;
    o_inc_pc   = 1'b0;
    o_z_in     = 1'b0;
    o_zlow_out = 1'b0;
    o_pc_in    = 1'b0;
    o_read     = 1'b0;
    o_mdr_in   = 1'b0;
    o_mdr_out  = 1'b0;
    o_ir_in    = 1'b0;
    o_gra      = 1'b0;
    o_r_out    = 1'b0;
    o_con_in   = 1'b0;
    o_y_in     = 1'b0;
    o_c_out    = 1'b0;
    o_add      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_T0;
      S_T0: begin
        o_pc_out = 1'b1;
        o_mar_in = 1'b1;
        o_inc_pc = 1'b1;
        o_z_in   = 1'b1;
        w_next   = S_T1;
      end
      S_T1: begin
        o_zlow_out = 1'b1;
        o_pc_in    = 1'b1;
        o_read     = 1'b1;
        o_mdr_in   = 1'b1;
        if (i_mem_ready)    w_next = S_T2;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_T2: begin
        o_mdr_out = 1'b1;
        o_ir_in   = 1'b1;
        w_next    = S_T3;
      end
      S_T3: begin
        // A non-branch opcode must not disturb the CON flip-flop or the register file.
        if (w_is_branch) begin
          o_gra    = 1'b1;
          o_r_out  = 1'b1;
          o_con_in = 1'b1;
          w_next   = S_T4;
        end else begin
          w_next   = S_IDLE;
        end
      end
      S_T4: begin
        o_pc_out = 1'b1;
        o_y_in   = 1'b1;
        w_next   = S_T5;
      end
      S_T5: begin
        o_c_out = 1'b1;
        o_add   = 1'b1;
        o_z_in  = 1'b1;
        w_next  = S_T6;
      end
      S_T6: begin
        o_zlow_out = 1'b1;
        o_pc_in    = i_con_ff;
        w_next     = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state        <= S_IDLE;
      r_wait         <= '0;
      r_err          <= 1'b0;
      r_taken        <= 1'b0;
      r_taken_cnt    <= '0;
      r_nottaken_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= ((r_state == S_T1) && !i_mem_ready && w_timeout) ||
                 ((r_state == S_T3) && !w_is_branch);
      if (r_state == S_T0) begin
        r_wait <= '0;
      end else if ((r_state == S_T1) && !i_mem_ready) begin
        r_wait <= r_wait + 1'b1;
      end
      if (r_state == S_T6) begin
        r_taken <= i_con_ff;
        if (i_con_ff) begin
          if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 1'b1;
        end else begin
          if (r_nottaken_cnt != '1) r_nottaken_cnt <= r_nottaken_cnt + 1'b1;
        end
      end
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_err          = r_err;
  assign o_taken        = r_taken;
  assign o_taken_cnt    = r_taken_cnt;
  assign o_nottaken_cnt = r_nottaken_cnt;

endmodule

// File: tb/tb_branch_step_sequencer.sv
// tb/tb_branch_step_sequencer.sv - randomized self-checking bench for branch_step_sequencer
module tb_branch_step_sequencer;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr, start, mem_ready, con_ff;
  logic [4:0]    ir_opcode;
  logic          pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, rd, mdr_in;
  logic          mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, add;
  logic          busy, done, taken, err;
  logic [CW-1:0] taken_cnt, nottaken_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int m_taken_cnt = 0;
  int m_nt_cnt    = 0;
  int m_taken     = 0;

  always #5 clk = ~clk;

  branch_step_sequencer #(.BR_OPCODE(5'b10010), .MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .i_clk(clk), .i_clr(clr), .i_start(start), .i_mem_ready(mem_ready),
    .i_ir_opcode(ir_opcode), .i_con_ff(con_ff),
    .o_pc_out(pc_out), .o_mar_in(mar_in), .o_inc_pc(inc_pc), .o_z_in(z_in),
    .o_zlow_out(zlow_out), .o_pc_in(pc_in), .o_read(rd), .o_mdr_in(mdr_in),
    .o_mdr_out(mdr_out), .o_ir_in(ir_in), .o_gra(gra), .o_r_out(r_out),
    .o_con_in(con_in), .o_y_in(y_in), .o_c_out(c_out), .o_add(add),
    .o_busy(busy), .o_done(done), .o_taken(taken), .o_err(err),
    .o_taken_cnt(taken_cnt), .o_nottaken_cnt(nottaken_cnt)
  );

  // {busy, done, err, pc_out, pc_in, con_in, read, zlow_out, gra, mdr_in, ir_in}
  wire [10:0] obs_vec = {busy, done, err, pc_out, pc_in, con_in, rd, zlow_out, gra, mdr_in, ir_in};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected controls in cycle k after the start edge, from the cycle-count timeline:
  // T0 at 1, fetch wait from 2 through 2+w (or 15 waits then abort), then T2..T6, DONE.
  function automatic logic [10:0] exp_vec(input int k, input int w, input bit op_ok, input bit con);
    bit tmo  = (w >= 15);
    int t1e  = tmo ? 16 : 2 + w;
    bit full = op_ok && !tmo;
    int last = tmo ? 16 : (op_ok ? t1e + 6 : t1e + 2);
    bit in1  = (k >= 2) && (k <= t1e);
    bit t3   = (k == t1e + 2) && full;
    bit t6   = (k == t1e + 5) && full;
    logic [10:0] v;
    v[10] = (k <= last);
    v[9]  = full && (k == t1e + 6);
    v[8]  = !full && (k == last + 1);
    v[7]  = (k == 1) || (full && k == t1e + 3);
    v[6]  = in1 || (t6 && con);
    v[5]  = t3;
    v[4]  = in1;
    v[3]  = in1 || t6;
    v[2]  = t3;
    v[1]  = in1;
    v[0]  = !tmo && (k == t1e + 1);
    return v;
  endfunction

  task automatic check_stats(input string tag);
    check_val({tag, "_taken"}, 32'(taken), 32'(m_taken));
    check_val({tag, "_tcnt"}, 32'(taken_cnt), 32'(m_taken_cnt));
    check_val({tag, "_ncnt"}, 32'(nottaken_cnt), 32'(m_nt_cnt));
  endtask

  // Entered at the negedge of an IDLE cycle; returns at the negedge of the IDLE cycle after it.
  task automatic run_txn(input int w, input bit op_ok, input bit con, input logic [4:0] bad_op);
    bit tmo  = (w >= 15);
    int t1e  = tmo ? 16 : 2 + w;
    int last = tmo ? 16 : (op_ok ? t1e + 6 : t1e + 2);
    ir_opcode = op_ok ? 5'b10010 : bad_op;
    con_ff    = con;
    start     = 1'b1;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      check_val($sformatf("ctl_w%0d_op%0d_c%0d_k%0d", w, op_ok, con, k), 32'(obs_vec),
                32'(exp_vec(k, w, op_ok, con)));
      if (k <= last) begin
        start     = 1'($urandom_range(0, 1));
        mem_ready = (k >= 2 + w);
      end
    end
    start = 1'b0;
    if (op_ok && !tmo) begin
      m_taken = con;
      if (con) begin
        if (m_taken_cnt < CMAX) m_taken_cnt++;
      end else begin
        if (m_nt_cnt < CMAX) m_nt_cnt++;
      end
    end
    check_stats($sformatf("st_w%0d_op%0d_c%0d", w, op_ok, con));
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; mem_ready = 1'b1; con_ff = 1'b0; ir_opcode = 5'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check_val("rst_ctl", 32'(obs_vec), 32'd0);
    check_stats("rst");

    run_txn(0, 1'b1, 1'b1, 5'b00011);
    run_txn(0, 1'b1, 1'b0, 5'b00011);
    run_txn(3, 1'b1, 1'b1, 5'b00011);
    run_txn(15, 1'b1, 1'b1, 5'b00011);
    run_txn(0, 1'b0, 1'b1, 5'b00011);
    run_txn(1, 1'b1, 1'b0, 5'b00011);

    // Two-cycle clear in the middle of T4 (cycle 5 with no fetch wait).
    ir_opcode = 5'b10010; con_ff = 1'b1; mem_ready = 1'b1; start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_val("midT4_pc_out", 32'(pc_out), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    check_val("clr1_ctl", 32'(obs_vec), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    m_taken = 0; m_taken_cnt = 0; m_nt_cnt = 0;
    check_val("clr2_ctl", 32'(obs_vec), 32'd0);
    check_stats("clr2");
    @(negedge clk);
    check_val("clr3_ctl", 32'(obs_vec), 32'd0);

    for (int i = 0; i < 450; i++) begin
      int r = $urandom_range(0, 99);
      int w = (r < 4) ? 15 : ((r < 70) ? 0 : $urandom_range(1, 4));
      bit op_ok = ($urandom_range(0, 99) >= 6);
      bit con = ($urandom_range(0, 99) < 80);
      logic [4:0] bad = 5'($urandom_range(0, 31));
      int gap = $urandom_range(0, 2);
      if (bad == 5'b10010) bad = 5'b00011;
      run_txn(w, op_ok, con, bad);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_val("gap_idle", 32'({busy, done, err}), 32'd0);
      end
    end
    check_val("sat_taken_cnt", 32'(taken_cnt), 32'(m_taken_cnt));
    check_val("sat_reached", 32'(m_taken_cnt == CMAX), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
